// File: rtl/mod_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, parallel load, wrap or
// saturate at the limits, a combinational terminal-count flag and a registered overflow pulse.
module mod_updown_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Top of the count range; MODULUS may equal 2**WIDTH, so it is held in 64 bits
  // and only the WIDTH-bit maximum is carried into the datapath.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  logic at_max, at_min;
  assign at_max = (q == MAXV);
  assign at_min = (q == '0);

  assign tc = up ? at_max : at_min;

  // Limits are tested before any +/-1, so no intermediate value exceeds WIDTH bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= (load_val > MAXV) ? MAXV : load_val;
      ovf <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (!SATURATE) q <= '0;
        end else begin
          q   <= q + 1'b1;
          ovf <= 1'b0;
        end
      end else begin
        if (at_min) begin
          ovf <= 1'b1;
          if (!SATURATE) q <= MAXV;
        end else begin
          q   <= q - 1'b1;
          ovf <= 1'b0;
        end
      end
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations share one stimulus stream,
// directed sequences first, then randomized controls, all against an integer model.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] lv;
  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  // d0: W4 M10 wrap, d1: W4 M10 saturate, d2: W3 M8 wrap (full range)
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .q(q0), .tc(tc0), .ovf(ovf0));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .q(q1), .tc(tc1), .ovf(ovf1));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
    .q(q2), .tc(tc2), .ovf(ovf2));

  int mod_n[3] = '{10, 10, 8};
  bit sat[3]   = '{1'b0, 1'b1, 1'b0};
  int mq[3];
  bit mo[3];
  int n_chk  = 0;
  int n_pass = 0;
  bit live   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int get_q(input int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  function automatic int get_tc(input int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int get_ovf(input int i);
    case (i)
      0: return int'(ovf0);
      1: return int'(ovf1);
      default: return int'(ovf2);
    endcase
  endfunction

  function automatic int exp_tc(input int i);
    return int'((up && mq[i] == mod_n[i] - 1) || (!up && mq[i] == 0));
  endfunction

  // Behavioural model: count range 0..M-1, clamp on load, wrap or hold at the ends.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (i == 2) ? int'(lv) % 8 : int'(lv);
      if (!rst) begin
        mq[i] = 0; mo[i] = 1'b0;
      end else if (load) begin
        mq[i] = (v > mod_n[i] - 1) ? mod_n[i] - 1 : v;
        mo[i] = 1'b0;
      end else if (en) begin
        if (up) begin
          mo[i] = (mq[i] == mod_n[i] - 1);
          if (!mo[i]) mq[i] = mq[i] + 1;
          else if (!sat[i]) mq[i] = 0;
        end else begin
          mo[i] = (mq[i] == 0);
          if (!mo[i]) mq[i] = mq[i] - 1;
          else if (!sat[i]) mq[i] = mod_n[i] - 1;
        end
      end else begin
        mo[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    live = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[d%0d]", i), get_q(i), mq[i]);
      chk($sformatf("ovf[d%0d]", i), get_ovf(i), int'(mo[i]));
      chk($sformatf("tc[d%0d]", i), get_tc(i), exp_tc(i));
    end
  endtask

  // Drive controls; tc must follow a change of up without waiting for an edge.
  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int v);
    rst = r; en = e; up = u; load = l; lv = 4'(v);
    #1;
    if (live)
      for (int i = 0; i < 3; i++)
        chk($sformatf("tc_comb[d%0d]", i), get_tc(i), exp_tc(i));
  endtask

  task automatic run(input int n, input bit r, input bit e, input bit u, input bit l, input int v);
    drive(r, e, u, l, v);
    repeat (n) tick();
  endtask

  initial begin
    bit ub;
    for (int i = 0; i < 3; i++) begin mq[i] = 0; mo[i] = 1'b0; end
    // reset, then wrap count up 12 edges
    run(2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("reset_q0", int'(q0), 0);
    run(12, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("wrap_end_q0", int'(q0), 2);
    // load 2, count down through 0
    run(1, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    run(4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("down_wrap_q0", int'(q0), 8);
    // saturate up from 8, then down from loaded 0
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, 8);
    run(4, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("sat_hi_q1", int'(q1), 9);
    chk("sat_hi_ovf1", int'(ovf1), 1);
    run(1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run(2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("sat_lo_q1", int'(q1), 0);
    // load clamp with en, then load with reset
    run(1, 1'b1, 1'b1, 1'b1, 1'b1, 13);
    chk("clamp_q0", int'(q0), 9);
    run(1, 1'b0, 1'b1, 1'b1, 1'b1, 6);
    chk("rst_over_load_q0", int'(q0), 0);
    // hold at 5, count to 7, mid-count reset, resume
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, 5);
    run(3, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("hold_q0", int'(q0), 5);
    run(2, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run(1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run(3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("resume_q0", int'(q0), 3);
    // full-range rollover on the 3-bit instance
    run(1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run(9, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("rollover_q2", int'(q2), 1);
    // randomized controls, direction in runs so the limits are reached
    ub = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) ub = ~ub;
      drive(($urandom_range(39) != 0), ($urandom_range(3) != 0), ub,
            ($urandom_range(9) == 0), int'($urandom_range(15)));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous counter. Successor to the fixed 4-bit ripple counter used in lab designs.
- All flops are clocked by a single clk; there is no ripple clocking. This keeps q glitch-free and lets downstream logic sample it every cycle.
- Adds configurable width and modulus, up/down direction, enable, parallel load, wrap or saturate mode, and overflow/terminal-count flags.
- Used as a generic event/cycle counter and as a divider source in datapath and testbench infrastructure.

Parameters:
- WIDTH, 4, bit width of q and load_val. Legal range is 1..32.
- MODULUS, 16, count range is 0..MODULUS-1. Legal range is 2..2**WIDTH. Elaboration error if outside this range.
- SATURATE, 0. 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  count enable.
- up  input  1  direction. 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational from q and up.
- ovf  output  1  registered one-cycle overflow/underflow pulse.

Behaviour:
- Reset
  - rst=0 at a clk rising edge sets q=0 and ovf=0.
  - Reset has absolute priority over load and en.
  - Reset is honoured mid-count; no partial update occurs.
  - No asynchronous path exists; q does not change between edges when rst falls.
- Priority per edge: reset, then load, then en, then hold.
- Load
  - load=1 sets q = min(load_val, MODULUS-1).
  - An out-of-range load_val is clamped to MODULUS-1, not truncated.
  - ovf is 0 on a load edge. load overrides en and up in the same cycle.
- Count, with en=1 and load=0
  - up=1, q<MODULUS-1: q=q+1, ovf=0.
  - up=1, q==MODULUS-1: SATURATE=0 gives q=0; SATURATE=1 gives q held. ovf=1 in both modes.
  - up=0, q>0: q=q-1, ovf=0.
  - up=0, q==0: SATURATE=0 gives q=MODULUS-1; SATURATE=1 gives q held at 0. ovf=1 in both modes.
- Hold: en=0 and load=0 keeps q unchanged and sets ovf=0.
- ovf timing
  - ovf is asserted for exactly the one cycle following the boundary edge.
  - Back-to-back boundary events, e.g. continuous counting in saturate mode, keep ovf high on each such cycle.
- tc timing
  - tc = (up && q==MODULUS-1) || (!up && q==0).
  - tc depends only on q and up; it does not depend on en.
  - tc changes in the same cycle that up changes.
- Arithmetic and width
  - Comparisons use WIDTH bits.
  - When MODULUS==2**WIDTH, the wrap behaviour equals natural binary rollover.
  - No intermediate value may exceed WIDTH bits. Use compare-before-increment, not an increment followed by a modulo.
- Direction change mid-count takes effect on the next enabled edge. No extra latency.
- Latency: each change to q is visible one clock after the sampled controls.
- After reset deassert (rst=1), counting begins on the first edge with en=1.

Test Plan:
- Reset and wrap count (WIDTH=4, MODULUS=10, SATURATE=0):
  - Stimulus: hold rst=0 for 2 edges, then rst=1, en=1, up=1 for 12 edges.
  - Expected: q=0,1,...,9,0,1,2. ovf=1 only in the cycle q returns to 0. tc=1 while q=9.
- Down wrap (same configuration):
  - Stimulus: load 2, then en=1, up=0 for 4 edges.
  - Expected: q=2,1,0,9,8. ovf=1 in the cycle q=9. tc=1 while q=0.
- Saturate (MODULUS=10, SATURATE=1):
  - Stimulus: load 8, then up=1 for 4 edges.
  - Expected: q=8,9,9,9,9. ovf high for the 3 cycles after the first attempt at 9.
  - Stimulus: then up=0 from a loaded 0.
  - Expected: q stays 0 and ovf=1.
- Load clamp and priority:
  - Stimulus: load_val=13 with load=1 and en=1.
  - Expected: q=9, ovf=0.
  - Stimulus: load=1 together with rst=0.
  - Expected: q=0.
- Hold and mid-operation reset:
  - Stimulus: counting up at q=5, drop en for 3 edges.
  - Expected: q stays 5 and ovf=0.
  - Stimulus: assert rst=0 for 1 edge while en=1 at q=7.
  - Expected: next q=0, and counting resumes from 0 once rst=1.
- Full-range rollover (WIDTH=3, MODULUS=8):
  - Stimulus: count up 9 edges from 0.
  - Expected: q sequence ends 7,0,1 with ovf=1 once.
